// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot loader that streams a framed program image onto the memory bus
//
// Purpose: hunts the serial stream for a sync string, then takes a big-endian
// 32-bit word count, the payload and a mod-256 checksum. Payload words are
// packed into DATA_W-wide beats and written through a req/gnt bus. The core
// is held in reset until a load succeeds; a fresh sync string re-programs it.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_i                asynchronous UART receive line, idle high
//   mem_req/mem_gnt     write handshake; gnt accepts the request in the same cycle
//   mem_we              always 1
//   mem_addr            beat address, BASE_ADDR + beat * DATA_W/8
//   mem_wdata/mem_wstrb beat data and byte strobes (partial on the final beat)
//   system_reset_no     active-low core reset, released after a good load
//   programming_active  high while receiving length, payload or checksum
//   prog_done           one-cycle pulse on a successful load
//   prog_error          sticky error flag, cleared by the next sync match
module uart_prog_loader #(
  parameter int unsigned           CLK_FREQ_HZ = 75_000_000,
  parameter int unsigned           BAUD_RATE   = 115200,
  parameter int unsigned           DATA_W      = 128,
  parameter logic [31:0]           BASE_ADDR   = 32'h0,
  parameter int unsigned           SYNC_LEN    = 9,
  parameter logic [8*SYNC_LEN-1:0] SYNC_SEQ    = "TEKNOFEST",
  parameter int unsigned           TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_i,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                system_reset_no,
  output logic                programming_active,
  output logic                prog_done,
  output logic                prog_error
);

  localparam int DIV        = int'(CLK_FREQ_HZ / BAUD_RATE);
  localparam int HALF_M1    = (DIV / 2 > 0) ? DIV / 2 - 1 : 0;
  localparam int CNT_W      = $clog2(DIV + 1);
  localparam int WPB        = int'(DATA_W / 32);
  localparam int WIDX_W     = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int STRB_W     = int'(DATA_W / 8);
  localparam int WIN_W      = int'(8 * SYNC_LEN);
  localparam logic [31:0] BEAT_BYTES = 32'(STRB_W);

  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_e;

  // RX path
  logic [1:0]       rx_sync_q, rx_sync_d;
  logic             rx_last_q, rx_last_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Loader
  state_e              state_q, state_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [23:0]         len_q, len_d;
  logic [1:0]          len_cnt_q, len_cnt_d;
  logic [31:0]         words_left_q, words_left_d;
  logic [23:0]         word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   beat_buf_q, beat_buf_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [31:0]         next_addr_q, next_addr_d;
  logic [7:0]          csum_q, csum_d;
  logic                csum_ok_q, csum_ok_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  // Registered outputs
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                prog_act_q, prog_act_d;
  logic                prog_done_q, prog_done_d;
  logic                prog_error_q, prog_error_d;

  logic [31:0]         n_words;
  logic [31:0]         word_full;
  logic [DATA_W-1:0]   beat_new;
  logic [STRB_W-1:0]   strb_new;

  // Bit-level receiver: mid-bit sampling from the falling edge of the start bit.
  always_comb begin
    rx_sync_d    = {rx_sync_q[0], rx_i};
    rx_last_d    = rx_sync_q[1];
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_HUNT: begin
        if (!rx_sync_q[1] && rx_last_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_W'(HALF_M1)) begin
          rx_cnt_d = '0;
          if (rx_sync_q[1]) begin
            rx_state_d = RX_HUNT;   // glitch, not a real start bit
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_W'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == CNT_W'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_HUNT;
          if (rx_sync_q[1]) byte_valid_d = 1'b1;
          else              frame_err_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Loader FSM and memory-side output register.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    len_d        = len_q;
    len_cnt_d    = len_cnt_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    beat_buf_d   = beat_buf_q;
    word_idx_d   = word_idx_q;
    next_addr_d  = next_addr_q;
    csum_d       = csum_q;
    csum_ok_d    = csum_ok_q;
    tmo_d        = tmo_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    sys_rst_n_d  = sys_rst_n_q;
    prog_done_d  = 1'b0;
    prog_error_d = prog_error_q;

    n_words   = {len_q, rx_shift_q};
    word_full = {word_q, rx_shift_q};
    beat_new  = beat_buf_q;
    beat_new[32*word_idx_q +: 32] = word_full;
    strb_new  = '0;
    for (int k = 0; k < WPB; k++) begin
      if (k <= int'(word_idx_q)) strb_new[4*k +: 4] = 4'hF;
    end

    if (mem_req_q && mem_gnt) mem_req_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid_q) begin
          win_d = WIN_W'({win_q, rx_shift_q});
          if (win_d == SYNC_SEQ) begin
            // Clearing the window keeps a stale match from re-firing on return.
            win_d        = '0;
            prog_error_d = 1'b0;
            sys_rst_n_d  = 1'b0;
            state_d      = ST_LEN;
            len_cnt_d    = '0;
            byte_cnt_d   = '0;
            word_idx_d   = '0;
            beat_buf_d   = '0;
            next_addr_d  = BASE_ADDR;
            csum_d       = '0;
            csum_ok_d    = 1'b0;
            tmo_d        = '0;
          end
        end
      end
      ST_LEN: begin
        if (byte_valid_q) begin
          csum_d    = csum_q + rx_shift_q;
          len_d     = {len_q[15:0], rx_shift_q};
          len_cnt_d = len_cnt_q + 1'b1;
          if (len_cnt_q == 2'd3) begin
            words_left_d = n_words;
            state_d      = (n_words == 32'd0) ? ST_CSUM : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid_q) begin
          csum_d     = csum_q + rx_shift_q;
          word_d     = {word_q[15:0], rx_shift_q};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == 32'd1 || word_idx_q == WIDX_W'(WPB - 1)) begin
              if (mem_req_q && !mem_gnt) begin
                // Overrun: leave the pending beat untouched.
                state_d = ST_ERR;
              end else begin
                mem_req_d   = 1'b1;
                mem_addr_d  = next_addr_q;
                mem_wdata_d = beat_new;
                mem_wstrb_d = strb_new;
                next_addr_d = next_addr_q + BEAT_BYTES;
                beat_buf_d  = '0;
                word_idx_d  = '0;
                if (words_left_q == 32'd1) state_d = ST_CSUM;
              end
            end else begin
              beat_buf_d = beat_new;
              word_idx_d = word_idx_q + 1'b1;
            end
          end
        end
      end
      ST_CSUM: begin
        if (byte_valid_q && !csum_ok_q) begin
          if (rx_shift_q == csum_q) begin
            if (!mem_req_q || mem_gnt) state_d   = ST_DONE;
            else                       csum_ok_d = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end else if (csum_ok_q && mem_req_q && mem_gnt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        prog_done_d = 1'b1;
        sys_rst_n_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        prog_error_d = 1'b1;
        sys_rst_n_d  = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // Inter-byte watchdog; a byte in the same cycle wins. Once the checksum
    // has matched no more bytes are expected, so only the bus is awaited.
    if (state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CSUM) begin
      if (byte_valid_q) begin
        tmo_d = '0;
      end else if (frame_err_q) begin
        state_d = ST_ERR;
      end else if (!csum_ok_q) begin
        if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) state_d = ST_ERR;
        else                                  tmo_d   = tmo_q + 1'b1;
      end
    end

    prog_act_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_q    <= 2'b11;
      rx_last_q    <= 1'b1;
      rx_state_q   <= RX_HUNT;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= ST_IDLE;
      win_q        <= '0;
      len_q        <= '0;
      len_cnt_q    <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      beat_buf_q   <= '0;
      word_idx_q   <= '0;
      next_addr_q  <= BASE_ADDR;
      csum_q       <= '0;
      csum_ok_q    <= 1'b0;
      tmo_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      sys_rst_n_q  <= 1'b0;
      prog_act_q   <= 1'b0;
      prog_done_q  <= 1'b0;
      prog_error_q <= 1'b0;
    end else begin
      rx_sync_q    <= rx_sync_d;
      rx_last_q    <= rx_last_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      win_q        <= win_d;
      len_q        <= len_d;
      len_cnt_q    <= len_cnt_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      beat_buf_q   <= beat_buf_d;
      word_idx_q   <= word_idx_d;
      next_addr_q  <= next_addr_d;
      csum_q       <= csum_d;
      csum_ok_q    <= csum_ok_d;
      tmo_q        <= tmo_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      sys_rst_n_q  <= sys_rst_n_d;
      prog_act_q   <= prog_act_d;
      prog_done_q  <= prog_done_d;
      prog_error_q <= prog_error_d;
    end
  end

  assign mem_req            = mem_req_q;
  assign mem_we             = 1'b1;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign mem_wstrb          = mem_wstrb_q;
  assign system_reset_no    = sys_rst_n_q;
  assign programming_active = prog_act_q;
  assign prog_done          = prog_done_q;
  assign prog_error         = prog_error_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int DATA_W = 128;
  localparam int DIV    = 10;
  localparam logic [127:0] B0  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] B1  = {96'h0, 32'h55555555};
  localparam logic [127:0] OB0 = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                rx_i = 1'b1;
  logic                mem_gnt = 1'b0;
  logic                mem_req, mem_we;
  logic [31:0]         mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                system_reset_no, programming_active, prog_done, prog_error;

  uart_prog_loader #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_W     (DATA_W),
    .BASE_ADDR  (32'h0),
    .SYNC_LEN   (9),
    .SYNC_SEQ   ("TEKNOFEST"),
    .TIMEOUT_CYC(1000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_i              (rx_i),
    .mem_req           (mem_req),
    .mem_gnt           (mem_gnt),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .system_reset_no   (system_reset_no),
    .programming_active(programming_active),
    .prog_done         (prog_done),
    .prog_error        (prog_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus responder and monitor: grants after gnt_delay cycles of held request,
  // records accepted beats and counts any change while a request waits.
  int           gnt_delay = 0;
  int           req_age = 0;
  bit           held = 1'b0;
  int           stab_viol = 0;
  int           stab_checks = 0;
  int           done_cnt = 0;
  logic [31:0]  hold_addr;
  logic [127:0] hold_data;
  logic [15:0]  hold_strb;
  logic [31:0]  rec_addr[$];
  logic [127:0] rec_data[$];
  logic [15:0]  rec_strb[$];

  always @(negedge clk) begin
    if (prog_done) done_cnt++;
    if (!rst_n || !mem_req) begin
      mem_gnt = 1'b0;
      held    = 1'b0;
      req_age = 0;
    end else begin
      if (held) begin
        stab_checks++;
        if (mem_addr !== hold_addr || mem_wdata !== hold_data || mem_wstrb !== hold_strb)
          stab_viol++;
      end
      hold_addr = mem_addr;
      hold_data = mem_wdata;
      hold_strb = mem_wstrb;
      if (req_age >= gnt_delay) begin
        mem_gnt = 1'b1;
        rec_addr.push_back(mem_addr);
        rec_data.push_back(mem_wdata);
        rec_strb.push_back(mem_wstrb);
        held    = 1'b0;
        req_age = 0;
      end else begin
        mem_gnt = 1'b0;
        held    = 1'b1;
        req_age++;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx_i = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      cyc(DIV);
    end
    rx_i = stop;
    cyc(DIV);
    rx_i = 1'b1;
    if (!stop) cyc(2 * DIV);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Length 5, words 11111111..55555555; correct checksum is 0x01.
  task automatic send_nominal(input logic [7:0] cs);
    send_word(32'd5);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    send_word(32'h55555555);
    send_byte(cs);
  endtask

  task automatic chk_two_beats(input string tag, input int first);
    chk({tag, " beat count"}, 128'(rec_addr.size()), 128'(first + 2));
    if (rec_addr.size() >= first + 2) begin
      chk({tag, " b0 addr"}, 128'(rec_addr[first]), 128'h0);
      chk({tag, " b0 data"}, rec_data[first], B0);
      chk({tag, " b0 strb"}, 128'(rec_strb[first]), 128'hFFFF);
      chk({tag, " b1 addr"}, 128'(rec_addr[first+1]), 128'h10);
      chk({tag, " b1 data"}, rec_data[first+1], B1);
      chk({tag, " b1 strb"}, 128'(rec_strb[first+1]), 128'h000F);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " mem_req"}, 128'(mem_req), 128'h0);
    chk({tag, " mem_addr"}, 128'(mem_addr), 128'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 128'h0);
    chk({tag, " mem_wstrb"}, 128'(mem_wstrb), 128'h0);
    chk({tag, " sys_rst_n"}, 128'(system_reset_no), 128'h0);
    chk({tag, " prog_act"}, 128'(programming_active), 128'h0);
    chk({tag, " prog_done"}, 128'(prog_done), 128'h0);
    chk({tag, " prog_error"}, 128'(prog_error), 128'h0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    cyc(5);
    chk_reset_vals("reset");
    chk("mem_we", 128'(mem_we), 128'h1);
    rst_n = 1'b1;
    cyc(20);

    // Framing error in IDLE: the dropped 'T' must not complete the sync string.
    send_str("TEKNOFES");
    send_byte("T", 1'b0);
    cyc(5);
    chk("frame prog_act", 128'(programming_active), 128'h0);
    chk("frame prog_error", 128'(prog_error), 128'h0);
    send_byte(8'h00);

    // Sync noise: only the final 'T' matches.
    send_str("TEKNOTEKNOFES");
    chk("noise no early match", 128'(programming_active), 128'h0);
    send_byte("T");
    chk("noise match prog_act", 128'(programming_active), 128'h1);
    chk("noise match sys_rst_n", 128'(system_reset_no), 128'h0);

    // Nominal load
    gnt_delay = 0;
    send_nominal(8'h01);
    cyc(20);
    chk_two_beats("nominal", 0);
    chk("nominal done pulses", 128'(done_cnt), 128'h1);
    chk("nominal sys_rst_n", 128'(system_reset_no), 128'h1);
    chk("nominal prog_error", 128'(prog_error), 128'h0);
    chk("nominal prog_act", 128'(programming_active), 128'h0);

    // Re-program on a fresh sync, then a bad checksum.
    send_str("TEKNOFEST");
    chk("reprog sys_rst_n", 128'(system_reset_no), 128'h0);
    chk("reprog prog_act", 128'(programming_active), 128'h1);
    send_nominal(8'h00);
    cyc(20);
    chk_two_beats("badcsum", 2);
    chk("badcsum prog_error", 128'(prog_error), 128'h1);
    chk("badcsum sys_rst_n", 128'(system_reset_no), 128'h0);
    chk("badcsum no done", 128'(done_cnt), 128'h1);

    // Backpressure: 30 cycles of gnt low per beat.
    gnt_delay = 30;
    send_str("TEKNOFEST");
    chk("bp error cleared", 128'(prog_error), 128'h0);
    send_nominal(8'h01);
    cyc(60);
    chk_two_beats("bp", 4);
    chk("bp done pulses", 128'(done_cnt), 128'h2);
    chk("bp sys_rst_n", 128'(system_reset_no), 128'h1);
    chk("bp hold seen", 128'(stab_checks > 0), 128'h1);
    chk("bp hold stable", 128'(stab_viol), 128'h0);

    // Overrun: gnt withheld for a whole beat period.
    gnt_delay = 1_000_000;
    send_str("TEKNOFEST");
    send_word(32'd8);
    for (int i = 0; i < 8; i++) send_word(32'hC0000000 + 32'(i));
    cyc(5);
    chk("ovr prog_error", 128'(prog_error), 128'h1);
    chk("ovr prog_act", 128'(programming_active), 128'h0);
    chk("ovr req pending", 128'(mem_req), 128'h1);
    chk("ovr addr kept", 128'(mem_addr), 128'h0);
    chk("ovr data kept", mem_wdata, OB0);
    chk("ovr strb kept", 128'(mem_wstrb), 128'hFFFF);
    gnt_delay = 0;
    cyc(4);
    chk("ovr req drained", 128'(mem_req), 128'h0);
    chk("ovr beat count", 128'(rec_addr.size()), 128'd7);
    if (rec_data.size() == 7) chk("ovr granted data", rec_data[6], OB0);
    chk("ovr hold stable", 128'(stab_viol), 128'h0);

    // Timeout inside DATA
    send_str("TEKNOFEST");
    chk("tmo error cleared", 128'(prog_error), 128'h0);
    send_word(32'd5);
    send_word(32'h11111111);
    send_word(32'h22222222);
    chk("tmo pre prog_act", 128'(programming_active), 128'h1);
    cyc(2000);
    chk("tmo prog_error", 128'(prog_error), 128'h1);
    chk("tmo prog_act", 128'(programming_active), 128'h0);
    chk("tmo no beat", 128'(mem_req), 128'h0);

    // Reset mid-DATA with a request pending
    gnt_delay = 1_000_000;
    send_str("TEKNOFEST");
    send_word(32'd5);
    for (int i = 0; i < 4; i++) send_word(32'hC0000000 + 32'(i));
    send_byte(8'hAB);
    chk("rst pre req", 128'(mem_req), 128'h1);
    rst_n = 1'b0;
    cyc(2);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    gnt_delay = 0;
    cyc(10);
    chk("post rst req", 128'(mem_req), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
